// File: rtl/operand_loader_pkg.sv
// Shared types and defaults for operand_loader and its button debouncers.
// Debouncer states use the fixed 2-bit encoding expected by the display-side tools.
package operand_loader_pkg;

  localparam int unsigned OP_W                    = 4;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEFAULT_CNT_W           = 18;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StArming    = 2'd1,
    StHeld      = 2'd2,
    StReleasing = 2'd3
  } deb_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce FSM for one active-high pushbutton.
// press pulses once per accepted press; held is high while the press is being held.
module btn_debounce
  import operand_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic held
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, sync_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn;
      sync_q  <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sync_q) begin
          state_d = StArming;
          cnt_d   = '0;
        end
      end
      StArming: begin
        if (!sync_q) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d = StHeld;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHeld: begin
        if (!sync_q) begin
          state_d = StReleasing;
          cnt_d   = '0;
        end
      end
      StReleasing: begin
        // A bounce during release returns to HELD so no second press is produced.
        if (sync_q) begin
          state_d = StHeld;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign held = (state_q == StHeld);

endmodule

// File: rtl/operand_loader.sv
// Turns switches and three debounced buttons into registered operands A/B with an update strobe.
// Optional auto-repeat on long holds: define OPERAND_LOADER_AUTOREPEAT_EN.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
`ifdef OPERAND_LOADER_AUTOREPEAT_EN
  ,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] sw,
  input  logic            btn_a,
  input  logic            btn_b,
  input  logic            btn_clr,
  output logic [OP_W-1:0] A,
  output logic [OP_W-1:0] B,
  output logic            a_valid,
  output logic            b_valid,
  output logic            upd
);

  logic [OP_W-1:0] sw_meta_q, sw_sync_q;
  logic            press_a, press_b, press_clr;
  logic            held_a, held_b, held_clr;
  logic [OP_W-1:0] a_q, a_d, b_q, b_d;
  logic            a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic            chg_q, upd_q;
  logic [1:0]      rep_fire;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_a (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_a),
    .press(press_a),
    .held (held_a)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_b (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_b),
    .press(press_b),
    .held (held_b)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_clr (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_clr),
    .press(press_clr),
    .held (held_clr)
  );

`ifdef OPERAND_LOADER_AUTOREPEAT_EN
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RepW  = $clog2(REPEAT_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES);
  localparam logic [RepW-1:0]  RepMax  = RepW'(REPEAT_CYCLES - 1);

  logic [1:0]            held_v, kill_q, kill_d;
  logic [1:0][HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0][RepW-1:0]  rep_cnt_q, rep_cnt_d;
  logic                  unused_held;

  assign held_v      = {held_b, held_a};
  assign unused_held = held_clr;

  // kill latches a clear seen mid-hold so repeats stay off until the button is let go.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    kill_d     = kill_q;
    rep_fire   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (!held_v[i]) begin
        hold_cnt_d[i] = '0;
        rep_cnt_d[i]  = '0;
        kill_d[i]     = 1'b0;
      end else if (press_clr || kill_q[i]) begin
        hold_cnt_d[i] = '0;
        rep_cnt_d[i]  = '0;
        kill_d[i]     = 1'b1;
      end else if (hold_cnt_q[i] != HoldMax) begin
        hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
      end else if (rep_cnt_q[i] == RepMax) begin
        rep_cnt_d[i] = '0;
        rep_fire[i]  = 1'b1;
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      kill_q     <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      kill_q     <= kill_d;
    end
  end
`else
  logic unused_held;
  assign unused_held = ^{held_a, held_b, held_clr};
  assign rep_fire    = 2'b00;
`endif

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    if (press_clr) begin
      a_d       = '0;
      b_d       = '0;
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else begin
      if (press_a) begin
        a_d       = sw_sync_q;
        a_valid_d = 1'b1;
      end
      if (press_b) begin
        b_d       = sw_sync_q;
        b_valid_d = 1'b1;
      end
      if (rep_fire[0]) a_d = a_q + OP_W'(1);
      if (rep_fire[1]) b_d = b_q + OP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      chg_q     <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      a_q       <= a_d;
      b_q       <= b_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      // Strobe trails the register write by one cycle; unchanged rewrites stay silent.
      chg_q     <= (a_d != a_q) || (b_d != b_q) || (a_valid_d != a_valid_q) ||
                   (b_valid_d != b_valid_q);
      upd_q     <= chg_q;
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign a_valid = a_valid_q;
  assign b_valid = b_valid_q;
  assign upd     = upd_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed sequences, a vector table and
// random button/switch activity compared against a run-length reference model.
module tb_operand_loader;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       btn_a = 1'b0, btn_b = 1'b0, btn_clr = 1'b0;
  logic [3:0] A, B;
  logic       a_valid, b_valid, upd;

  int total = 0;
  int bad = 0;
  int upd_cnt = 0;
  bit model_on = 1'b1;

  operand_loader #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
`ifdef OPERAND_LOADER_AUTOREPEAT_EN
    ,
    .HOLD_CYCLES    (8),
    .REPEAT_CYCLES  (3)
`endif
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .btn_a  (btn_a),
    .btn_b  (btn_b),
    .btn_clr(btn_clr),
    .A      (A),
    .B      (B),
    .a_valid(a_valid),
    .b_valid(b_valid),
    .upd    (upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) if (upd === 1'b1) upd_cnt++;

  // Reference model: a button level is accepted once the synchronised input has held the
  // opposite level for D+1 consecutive cycles; accepting a 1 is a press.
  logic [2:0] m_s1, m_s2, m_cur, m_acc, m_press;
  int         m_run [3];
  logic [3:0] m_sw1, m_sw2, m_a, m_b, m_na, m_nb;
  logic       m_va, m_vb, m_nva, m_nvb, m_chg, m_upd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_cur = '0; m_acc = '0; m_press = '0;
      m_sw1 = '0; m_sw2 = '0; m_a = '0; m_b = '0; m_va = 0; m_vb = 0;
      m_chg = 0; m_upd = 0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
    end else begin
      m_na = m_a; m_nb = m_b; m_nva = m_va; m_nvb = m_vb;
      if (m_press[2]) begin
        m_na = 0; m_nb = 0; m_nva = 0; m_nvb = 0;
      end else begin
        if (m_press[0]) begin m_na = m_sw2; m_nva = 1; end
        if (m_press[1]) begin m_nb = m_sw2; m_nvb = 1; end
      end
      m_upd = m_chg;
      m_chg = {m_na, m_nb, m_nva, m_nvb} != {m_a, m_b, m_va, m_vb};
      m_a = m_na; m_b = m_nb; m_va = m_nva; m_vb = m_nvb;
      m_s2 = m_s1; m_s1 = {btn_clr, btn_b, btn_a};
      m_sw2 = m_sw1; m_sw1 = sw;
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] == m_cur[i]) m_run[i]++;
        else begin m_cur[i] = m_s2[i]; m_run[i] = 1; end
        m_press[i] = 1'b0;
        if (m_cur[i] != m_acc[i] && m_run[i] == D + 1) begin
          m_acc[i]   = m_cur[i];
          m_press[i] = m_cur[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_A", {4'h0, A}, {4'h0, m_a});
      check("model_B", {4'h0, B}, {4'h0, m_b});
      check("model_valid", {6'h0, a_valid, b_valid}, {6'h0, m_va, m_vb});
      check("model_upd", {7'h0, upd}, {7'h0, m_upd});
    end
  end

  typedef struct {
    logic [2:0] btns;  // {clr, b, a}
    logic [3:0] swv;
    logic [3:0] ea, eb;
    logic       eva, evb;
    int         eupd;
  } vec_t;

  vec_t vecs [12];

  task automatic press_btns(input logic [2:0] m, input logic [3:0] v);
    sw = v; btn_a = m[0]; btn_b = m[1]; btn_clr = m[2];
    tick(8);
    btn_a = 0; btn_b = 0; btn_clr = 0;
    tick(14);
  endtask

  initial begin
`ifdef OPERAND_LOADER_AUTOREPEAT_EN
    model_on = 1'b0;
`endif
    vecs[0]  = '{3'b001, 4'h5, 4'h5, 4'h3, 1, 1, 1};
    vecs[1]  = '{3'b010, 4'h7, 4'h5, 4'h7, 1, 1, 1};
    vecs[2]  = '{3'b101, 4'hC, 4'h0, 4'h0, 0, 0, 1};  // clear beats load
    vecs[3]  = '{3'b100, 4'h1, 4'h0, 4'h0, 0, 0, 0};  // clear of cleared state
    vecs[4]  = '{3'b001, 4'h6, 4'h6, 4'h0, 1, 0, 1};
    vecs[5]  = '{3'b001, 4'h6, 4'h6, 4'h0, 1, 0, 0};  // identical reload
    vecs[6]  = '{3'b001, 4'h7, 4'h7, 4'h0, 1, 0, 1};
    vecs[7]  = '{3'b011, 4'hA, 4'hA, 4'hA, 1, 1, 1};  // both load same value
    vecs[8]  = '{3'b010, 4'hA, 4'hA, 4'hA, 1, 1, 0};
    vecs[9]  = '{3'b010, 4'h0, 4'hA, 4'h0, 1, 1, 1};
    vecs[10] = '{3'b100, 4'h3, 4'h0, 4'h0, 0, 0, 1};
    vecs[11] = '{3'b010, 4'h0, 4'h0, 4'h0, 0, 1, 1};  // validity-only change

    // Reset with everything asserted.
    sw = 4'hF; btn_a = 1; btn_b = 1; btn_clr = 1;
    tick(3);
    check("rst_outputs", {A, B}, 8'h00);
    check("rst_flags", {5'h0, a_valid, b_valid, upd}, 8'h00);
    btn_b = 0; btn_clr = 0; rst = 1;
    tick(6);
    check("post_rst_no_early_press", {4'h0, A}, 8'h00);
    tick(1);
    check("post_rst_load", {3'h0, a_valid, A}, 8'h1F);
    check("post_rst_upd_lag", {7'h0, upd}, 8'h00);
    tick(1);
    check("post_rst_upd", {7'h0, upd}, 8'h01);
    tick(1);
    btn_a = 0;
    tick(12);

    // Clean pulse, exact latency.
    upd_cnt = 0;
    sw = 4'h9; btn_a = 1;
    tick(6);
    check("lat_a_before", {4'h0, A}, 8'h0F);
    tick(1);
    check("lat_a_load", {3'h0, a_valid, A}, 8'h19);
    check("lat_upd_lag", {7'h0, upd}, 8'h00);
    tick(1);
    check("lat_upd_pulse", {7'h0, upd}, 8'h01);
    tick(1);
    check("lat_upd_end", {7'h0, upd}, 8'h00);
    tick(1);
    btn_a = 0;
    tick(12);
    check("lat_b_untouched", {3'h0, b_valid, B}, 8'h00);
    check("lat_upd_count", 8'(upd_cnt), 8'd1);

    // Bouncing load-B.
    upd_cnt = 0;
    sw = 4'h3;
    btn_b = 1; tick(1); btn_b = 0; tick(1); btn_b = 1; tick(1); btn_b = 0; tick(1);
    btn_b = 1;
    tick(6);
    check("bounce_no_load", {3'h0, b_valid, B}, 8'h00);
    tick(1);
    check("bounce_load", {3'h0, b_valid, B}, 8'h13);
    tick(3);
    btn_b = 0;
    tick(12);
    check("bounce_upd_count", 8'(upd_cnt), 8'd1);

    for (int i = 0; i < 12; i++) begin
      upd_cnt = 0;
      press_btns(vecs[i].btns, vecs[i].swv);
      check($sformatf("vec%0d_AB", i), {A, B}, {vecs[i].ea, vecs[i].eb});
      check($sformatf("vec%0d_valid", i), {6'h0, a_valid, b_valid},
            {6'h0, vecs[i].eva, vecs[i].evb});
      check($sformatf("vec%0d_upd", i), 8'(upd_cnt), 8'(vecs[i].eupd));
    end

`ifdef OPERAND_LOADER_AUTOREPEAT_EN
    // Long hold: load E, then repeat steps to F and 0.
    upd_cnt = 0;
    sw = 4'hE; btn_a = 1;
    tick(7);
    check("ar_load", {4'h0, A}, 8'h0E);
    tick(10);
    check("ar_before_step", {4'h0, A}, 8'h0E);
    tick(1);
    check("ar_step1", {4'h0, A}, 8'h0F);
    tick(2);
    btn_a = 0;
    tick(1);
    check("ar_step2", {4'h0, A}, 8'h00);
    tick(15);
    check("ar_after_release", {3'h0, a_valid, A}, 8'h10);
    check("ar_upd_count", 8'(upd_cnt), 8'd3);
`else
    // Random activity, including one asynchronous reset mid-debounce.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) btn_a = ~btn_a;
      if ($urandom_range(0, 5) == 0) btn_b = ~btn_b;
      if ($urandom_range(0, 19) == 0) btn_clr = ~btn_clr;
      if ($urandom_range(0, 3) == 0) sw = 4'($urandom);
      if (c == 1500) begin
        #2 rst = 0;
      end
      if (c == 1503) rst = 1;
    end
    btn_a = 0; btn_b = 0; btn_clr = 0;
    tick(15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream input stage for the seven-segment display driver. It turns board switches and pushbuttons into the stable 4-bit operands A and B that the display consumes.
- Synchronises and debounces three buttons (load A, load B, clear). Latches sw[3:0] into A or B on a debounced press.
- Issues a one-cycle update strobe whenever either operand changes.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a button level is accepted (5 ms at 50 MHz)
- CNT_W, 18, width of the debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
- OP_W, 4, operand width

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- sw  input  OP_W  raw switch value; asynchronous to clk
- btn_a  input  1  raw load-A button; active-high, bouncy
- btn_b  input  1  raw load-B button; active-high, bouncy
- btn_clr  input  1  raw clear button; active-high, bouncy
- A  output  OP_W  registered operand A
- B  output  OP_W  registered operand B
- a_valid  output  1  A has been loaded since the last reset or clear
- b_valid  output  1  B has been loaded since the last reset or clear
- upd  output  1  one-cycle pulse, the cycle after A or B changes value or validity

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is asynchronous active-low. While rst=0: A=0, B=0, a_valid=0, b_valid=0, upd=0, all synchronisers 0, all debouncers in IDLE with counter 0.
- Synchronisers: each button and each sw bit passes through a 2-FF synchroniser. sw is sampled only from its synchronised copy.
- Debouncer FSM, one per button:
  - IDLE: sync=0. On sync=1, go to ARMING and set counter=0.
  - ARMING: counter increments while sync=1. If sync drops to 0, return to IDLE with no press. When counter reaches DEBOUNCE_CYCLES-1, go to HELD and assert press for exactly one cycle.
  - HELD: on sync=0, go to RELEASING and set counter=0.
  - RELEASING: counter increments while sync=0. If sync returns to 1, go back to HELD. When counter reaches DEBOUNCE_CYCLES-1, go to IDLE.
- Press latency: a raw clean edge produces press 2 + DEBOUNCE_CYCLES cycles later. Exactly one press is generated per physical press, regardless of hold time.
- Load rules, evaluated on press cycles:
  - press_clr: A=0, B=0, a_valid=0, b_valid=0.
  - press_a without clr: A = synchronised sw, a_valid=1.
  - press_b without clr: B = synchronised sw, b_valid=1.
  - Simultaneous press_a and press_b: both load the same sw value.
  - Clear has priority over any simultaneous load.
- upd: asserted one cycle after any register write that changes A, B, a_valid or b_valid. Reloading an identical value into an already-valid operand does not assert upd. A clear with both operands already clear and zero does not assert upd.
- Outputs are fully registered. No combinational path from any input to any output.
- Reset mid-debounce: every FSM returns to IDLE immediately. A button still held at reset release is treated as a new press and needs the full debounce.

Optional Feature:
- Macro: OPERAND_LOADER_AUTOREPEAT_EN.
- Defined:
  - Adds parameters HOLD_CYCLES (default 25000000) and REPEAT_CYCLES (default 5000000).
  - While load-A or load-B stays in HELD for more than HOLD_CYCLES, the matching operand increments modulo 2**OP_W every REPEAT_CYCLES. Each increment sets upd.
  - Clear and reset abort auto-repeat.
- Undefined: no hold counter is present and HELD never modifies the operands.

Decomposition:
- Shared package operand_loader_pkg:
  - Debouncer state encoding IDLE=2'd0, ARMING=2'd1, HELD=2'd2, RELEASING=2'd3.
  - Default DEBOUNCE_CYCLES.
  - OP_W.
- Sub-module btn_debounce (parameters DEBOUNCE_CYCLES, CNT_W):
  - Contains the 2-FF synchroniser and the FSM.
  - Outputs press and held.
  - Instantiated three times.

Test Plan (bench uses DEBOUNCE_CYCLES=4 and CNT_W=3 unless noted):
1. Hold rst=0 with sw=4'hF and all buttons high, then release rst. Required: A=0, B=0, both valid flags 0 and upd=0 during reset. After release, the first press arrives only after the full debounce.
2. sw=4'h9, clean btn_a pulse lasting 10 cycles. Required: A=4'h9 and a_valid=1 exactly 2+4 cycles after the rising edge; upd high for one cycle the next cycle; B unchanged.
3. btn_b bounces 1,0,1,0 at one-cycle intervals, then holds 1, with sw=4'h3. Required: no load during the bounces; B=4'h3 once 4 stable cycles are reached; exactly one upd.
4. A=5, B=7 both valid; btn_clr and btn_a pressed on the same cycle with sw=4'hC. Required: A=0, B=0, both valid flags 0; the load is ignored; one upd.
5. A=4'h6 valid; press btn_a again with sw=4'h6. Required: A stays 4'h6 and upd stays 0. Then press btn_a with sw=4'h7: A=4'h7 and upd pulses once.
6. With OPERAND_LOADER_AUTOREPEAT_EN, HOLD_CYCLES=8, REPEAT_CYCLES=3, A=4'hE: hold btn_a for 20 cycles. Required: A steps E, F, 0 with upd on each step; no change after release.
